// File: rtl/mult.sv
// Sequential 32x32 signed radix-2 Booth multiplier, one Booth step per clock.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands complete in one cycle via DONE.
module mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  input  logic        multInit,
  output logic        multStop,
  output logic        multBusy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [32:0] r_M;
  logic [32:0] r_acc;
  logic [31:0] r_Q;
  logic        r_q1;
  logic [5:0]  r_count;
  logic        r_stop;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_sum;
  logic [32:0] w_acc_sh;
  logic [31:0] w_Q_sh;
  logic        w_q1_sh;
  logic        w_last;
  logic [5:0]  w_count_nxt;

  // Booth add/subtract followed by arithmetic right shift of {acc, Q, q_1}
  always_comb begin
    w_sum = r_acc;
    case ({r_Q[0], r_q1})
      2'b01:   w_sum = r_acc + r_M;
      2'b10:   w_sum = r_acc - r_M;
      default: w_sum = r_acc;
    endcase
    w_acc_sh    = {w_sum[32], w_sum[32:1]};
    w_Q_sh      = {w_sum[0], r_Q[31:1]};
    w_q1_sh     = r_Q[0];
    w_last      = (r_count == 6'd31);
    w_count_nxt = r_count + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_M     <= '0;
      r_acc   <= '0;
      r_Q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stop <= 1'b0;
          if (multInit) begin
            r_busy <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
            if ((value_A == '0) || (value_B == '0)) begin
              r_hi    <= '0;
              r_lo    <= '0;
              r_stop  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_M     <= {value_A[31], value_A};
              r_acc   <= '0;
              r_Q     <= value_B;
              r_q1    <= 1'b0;
              r_count <= '0;
              r_state <= S_RUN;
            end
`else
            r_M     <= {value_A[31], value_A};
            r_acc   <= '0;
            r_Q     <= value_B;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_state <= S_RUN;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_sh;
          r_Q     <= w_Q_sh;
          r_q1    <= w_q1_sh;
          r_count <= w_count_nxt;
          if (w_last) begin
            // product comes from the post-shift values of this final step
            r_hi    <= w_acc_sh[31:0];
            r_lo    <= w_Q_sh;
            r_stop  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign multStop = r_stop;
  assign multBusy = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
